// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture controller.
//  - FSM state encodings (OFF / WAKE / FLUSH / RUN)
//  - clog2 helper used to size counters and pointers
package adc_capture_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAKE  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    // Ceiling log2, never less than 1 so the result is always a usable width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = 32'(i + 1);
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//  clk, rst        clock, asynchronous active-high reset
//  push, push_data write request and data (accepted if not full or popping)
//  pop             read request (ignored when empty)
//  pop_data        word at the head of the FIFO
//  full, empty     registered status flags
module adc_sync_fifo
    import adc_capture_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        push_ok   = push && (!full || pop);
        pop_ok    = pop && !empty;
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/adc_capture_ctrl.sv
// AD9283-class ADC front end: clock divider, power sequencing, pipeline
// flush, optional 2^AVG_LOG2 averaging and an output FIFO on a valid/ready
// stream. All logic is in the CLK domain.
// Ports:
//  CLK, RST     system clock, asynchronous active-high reset
//  EN           1 = capture, 0 = power ADC down
//  ADC_CLK      ADC sample clock (CLK / (2*CLK_DIV))
//  ADC_PWR      ADC power-down pin, 1 = powered down
//  ADC_Din      ADC output bus
//  DOUT         result at FIFO head; DOUT_VALID = FIFO non-empty
//  DOUT_READY   consumer accepts DOUT
//  OVERFLOW     sticky drop flag, cleared by CLR_OVF (a drop wins)
//  RUNNING      FSM is in RUN
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned PWRUP_CYC  = 1024,
    parameter int unsigned PIPE_LAT   = 4,
    parameter int unsigned AVG_LOG2   = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    output logic              ADC_CLK,
    output logic              ADC_PWR,
    input  logic [DATA_W-1:0] ADC_Din,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              OVERFLOW,
    input  logic              CLR_OVF,
    output logic              RUNNING
);

    localparam int unsigned DIV_W = clog2(CLK_DIV);
    localparam int unsigned SET_W = clog2(PWRUP_CYC);
    localparam int unsigned FL_W  = clog2(PIPE_LAT + 1);
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(PWRUP_CYC - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [AVG_W-1:0] AVG_LAST = AVG_W'((1 << AVG_LOG2) - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic              tc;
    logic              strobe;
    logic [DATA_W-1:0] din_s;
    logic              sample_v;
    logic [SET_W-1:0]  settle_cnt;
    logic [FL_W-1:0]   flush_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [AVG_W-1:0]  avg_cnt;
    logic [DATA_W-1:0] res_data;
    logic              res_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; EN low overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF: begin
                if (EN) begin
                    state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (settle_cnt == SET_LAST) begin
                    state_nxt = (PIPE_LAT == 0) ? ST_RUN : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (sample_v && (flush_cnt == FL_LAST)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_OFF;
        endcase
        if (!EN) begin
            state_nxt = ST_OFF;
        end
    end

    // Status outputs follow the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ADC_PWR <= 1'b1;
            RUNNING <= 1'b0;
        end else begin
            ADC_PWR <= (state_nxt == ST_OFF);
            RUNNING <= (state_nxt == ST_RUN);
        end
    end

    // Strobe marks the CLK edge on which ADC_CLK falls.
    assign tc     = (div_cnt == DIV_LAST);
    assign strobe = (state != ST_OFF) && tc && ADC_CLK;

    // ADC clock divider; held low while OFF or entering OFF.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            ADC_CLK <= 1'b0;
        end else if (state_nxt == ST_OFF) begin
            div_cnt <= '0;
            ADC_CLK <= 1'b0;
        end else if (state != ST_OFF) begin
            if (tc) begin
                div_cnt <= '0;
                ADC_CLK <= ~ADC_CLK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Capture on ADC_CLK fall; sample_v presents it to FLUSH/RUN one edge later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            din_s    <= '0;
            sample_v <= 1'b0;
        end else begin
            if (strobe) begin
                din_s <= ADC_Din;
            end
            sample_v <= strobe && (state_nxt != ST_OFF);
        end
    end

    // Power-up settle and pipeline flush counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            settle_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if ((state == ST_WAKE) && (state_nxt == ST_WAKE)) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end else begin
                settle_cnt <= '0;
            end
            if (state_nxt != ST_FLUSH) begin
                flush_cnt <= '0;
            end else if ((state == ST_FLUSH) && sample_v) begin
                flush_cnt <= flush_cnt + FL_W'(1);
            end
        end
    end

    // Accumulator; the final sample of a group is included in the pushed sum.
    assign acc_sum = acc + ACC_W'(din_s);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc      <= '0;
            avg_cnt  <= '0;
            res_data <= '0;
            res_push <= 1'b0;
        end else begin
            res_push <= 1'b0;
            if (state_nxt != ST_RUN) begin
                acc     <= '0;
                avg_cnt <= '0;
            end else if ((state == ST_RUN) && sample_v) begin
                if (avg_cnt == AVG_LAST) begin
                    res_data <= DATA_W'(acc_sum >> AVG_LOG2);
                    res_push <= 1'b1;
                    acc      <= '0;
                    avg_cnt  <= '0;
                end else begin
                    acc     <= acc_sum;
                    avg_cnt <= avg_cnt + AVG_W'(1);
                end
            end
        end
    end

    assign pop        = DOUT_VALID && DOUT_READY;
    assign DOUT_VALID = !fifo_empty;
    assign drop       = res_push && fifo_full && !pop;

    adc_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (res_push),
        .push_data (res_data),
        .pop       (pop),
        .pop_data  (DOUT),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky overflow; a drop in the same cycle as CLR_OVF keeps it set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (drop) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a pass-through instance (u0) and a
// 4-sample averaging instance (u2), both with CLK_DIV=2, PWRUP_CYC=8,
// PIPE_LAT=2, FIFO_DEPTH=4. ADC data is fed from queues, one value per
// ADC_CLK fall; accepted stream words are collected into queues.
module tb_adc_capture_ctrl;

    logic       CLK;
    logic       RST;
    logic       en0, ready0, clr0;
    logic [7:0] din0;
    logic       adc_clk0, adc_pwr0, vld0, ovf0, run0;
    logic [7:0] dout0;
    logic       en2, ready2, clr2;
    logic [7:0] din2;
    logic       adc_clk2, adc_pwr2, vld2, ovf2, run2;
    logic [7:0] dout2;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx0[$];
    logic [7:0] rx0[$];
    logic [7:0] tx2[$];
    logic [7:0] rx2[$];
    logic       prev_clk0 = 1'b0;
    logic       prev_clk2 = 1'b0;
    int         run_falls2 = 0;

    typedef struct packed {
        logic pwr;
        logic clk;
        logic run;
        logic vld;
    } seq_t;

    typedef struct packed {
        logic [0:3][7:0] s;
        logic [7:0]      exp;
    } avg_vec_t;

    localparam int N_SEQ = 20;
    localparam int N_AVG = 5;
    seq_t     seq_tab [N_SEQ];
    avg_vec_t avg_tab [N_AVG];

    adc_capture_ctrl #(
        .DATA_W(8), .CLK_DIV(2), .PWRUP_CYC(8), .PIPE_LAT(2), .AVG_LOG2(0), .FIFO_DEPTH(4)
    ) u0 (
        .CLK(CLK), .RST(RST), .EN(en0), .ADC_CLK(adc_clk0), .ADC_PWR(adc_pwr0),
        .ADC_Din(din0), .DOUT(dout0), .DOUT_VALID(vld0), .DOUT_READY(ready0),
        .OVERFLOW(ovf0), .CLR_OVF(clr0), .RUNNING(run0)
    );

    adc_capture_ctrl #(
        .DATA_W(8), .CLK_DIV(2), .PWRUP_CYC(8), .PIPE_LAT(2), .AVG_LOG2(2), .FIFO_DEPTH(4)
    ) u2 (
        .CLK(CLK), .RST(RST), .EN(en2), .ADC_CLK(adc_clk2), .ADC_PWR(adc_pwr2),
        .ADC_Din(din2), .DOUT(dout2), .DOUT_VALID(vld2), .DOUT_READY(ready2),
        .OVERFLOW(ovf2), .CLR_OVF(clr2), .RUNNING(run2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One CLK cycle: record accepted words, feed the next ADC value on each ADC_CLK fall.
    task automatic step();
        logic       t0, t2;
        logic [7:0] d0, d2;
        t0 = vld0 && ready0;
        d0 = dout0;
        t2 = vld2 && ready2;
        d2 = dout2;
        @(posedge CLK);
        #1;
        if (t0) rx0.push_back(d0);
        if (t2) rx2.push_back(d2);
        if (prev_clk0 && !adc_clk0 && (tx0.size() > 0)) din0 = tx0.pop_front();
        if (prev_clk2 && !adc_clk2) begin
            if (run2) run_falls2++;
            if (tx2.size() > 0) din2 = tx2.pop_front();
        end
        prev_clk0 = adc_clk0;
        prev_clk2 = adc_clk2;
    endtask

    initial begin
        int cnt;

        // {pwr, clk, run, vld} after each edge, edge 0 being the one that samples EN=1.
        seq_tab[0]  = 4'b0000; seq_tab[1]  = 4'b0000; seq_tab[2]  = 4'b0100; seq_tab[3]  = 4'b0100;
        seq_tab[4]  = 4'b0000; seq_tab[5]  = 4'b0000; seq_tab[6]  = 4'b0100; seq_tab[7]  = 4'b0100;
        seq_tab[8]  = 4'b0000; seq_tab[9]  = 4'b0000; seq_tab[10] = 4'b0100; seq_tab[11] = 4'b0100;
        seq_tab[12] = 4'b0000; seq_tab[13] = 4'b0010; seq_tab[14] = 4'b0110; seq_tab[15] = 4'b0110;
        seq_tab[16] = 4'b0010; seq_tab[17] = 4'b0010; seq_tab[18] = 4'b0111; seq_tab[19] = 4'b0110;

        avg_tab[0].s = {8'h01, 8'h02, 8'h03, 8'h06}; avg_tab[0].exp = 8'h03;
        avg_tab[1].s = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; avg_tab[1].exp = 8'hFF;
        avg_tab[2].s = {8'h10, 8'h20, 8'h30, 8'h41}; avg_tab[2].exp = 8'h28;
        avg_tab[3].s = {8'h00, 8'h00, 8'h00, 8'h03}; avg_tab[3].exp = 8'h00;
        avg_tab[4].s = {8'h80, 8'h80, 8'h80, 8'h7F}; avg_tab[4].exp = 8'h7F;

        RST = 1'b1;
        en0 = 1'b0; ready0 = 1'b0; clr0 = 1'b0; din0 = 8'hEE;
        en2 = 1'b0; ready2 = 1'b0; clr2 = 1'b0; din2 = 8'hEE;

        // Reset values.
        #12;
        check("rst pwr",     32'(adc_pwr0), 32'd1);
        check("rst adc_clk", 32'(adc_clk0), 32'd0);
        check("rst valid",   32'(vld0),     32'd0);
        check("rst dout",    32'(dout0),    32'd0);
        check("rst ovf",     32'(ovf0),     32'd0);
        check("rst running", 32'(run0),     32'd0);

        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) step();
        check("idle pwr", 32'(adc_pwr0), 32'd1);
        check("idle clk", 32'(adc_clk0), 32'd0);

        // Wake-up, flush and first-result latency on the pass-through instance.
        for (int i = 0; i < 32; i++) tx0.push_back(8'(8'h10 + i));
        ready0 = 1'b1;
        en0    = 1'b1;
        for (int k = 0; k < N_SEQ; k++) begin
            step();
            check($sformatf("seq%0d pwr", k),   32'(adc_pwr0), 32'(seq_tab[k].pwr));
            check($sformatf("seq%0d clk", k),   32'(adc_clk0), 32'(seq_tab[k].clk));
            check($sformatf("seq%0d run", k),   32'(run0),     32'(seq_tab[k].run));
            check($sformatf("seq%0d valid", k), 32'(vld0),     32'(seq_tab[k].vld));
        end

        // Ramp stream: flushed samples never appear.
        for (int i = 0; i < 40 && rx0.size() < 5; i++) step();
        check("ramp count", 32'(rx0.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx0.size(); i++)
            check($sformatf("ramp word%0d", i), 32'(rx0[i]), 32'(8'h12 + i));

        // Stall: FIFO fills with 0x17..0x1A, further results are dropped.
        ready0 = 1'b0;
        for (int i = 0; i < 40 && !ovf0; i++) step();
        check("ovf set",       32'(ovf0),  32'd1);
        check("ovf head valid", 32'(vld0), 32'd1);
        check("ovf head dout", 32'(dout0), 32'h17);
        clr0 = 1'b1;
        step();
        check("ovf cleared", 32'(ovf0), 32'd0);
        for (int i = 0; i < 8 && !ovf0; i++) step();
        check("ovf set wins over clr", 32'(ovf0), 32'd1);
        clr0 = 1'b0;

        // Power down keeps FIFO contents and the sticky flag.
        en0 = 1'b0;
        step();
        check("off pwr",     32'(adc_pwr0), 32'd1);
        check("off clk",     32'(adc_clk0), 32'd0);
        check("off running", 32'(run0),     32'd0);
        repeat (10) step();
        check("off ovf held",  32'(ovf0),  32'd1);
        check("off valid",     32'(vld0),  32'd1);
        check("off dout held", 32'(dout0), 32'h17);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("ovf clr pulse", 32'(ovf0), 32'd0);
        ready0 = 1'b1;
        for (int i = 0; i < 10 && rx0.size() < 9; i++) step();
        check("drain count", 32'(rx0.size()), 32'd9);
        for (int i = 5; i < 9 && i < rx0.size(); i++)
            check($sformatf("drain word%0d", i - 5), 32'(rx0[i]), 32'(8'h17 + i - 5));
        check("drain empty", 32'(vld0), 32'd0);

        // Averaging instance: two flushed samples, table groups, then a partial group.
        tx2.push_back(8'hAA);
        tx2.push_back(8'hBB);
        for (int r = 0; r < N_AVG; r++)
            for (int j = 0; j < 4; j++) tx2.push_back(avg_tab[r].s[j]);
        tx2.push_back(8'h77);
        tx2.push_back(8'h77);
        ready2 = 1'b1;
        en2    = 1'b1;
        for (int i = 0; i < 200 && run_falls2 < 4 * N_AVG + 2; i++) step();
        check("avg sample count", 32'(run_falls2), 32'(4 * N_AVG + 2));
        en2 = 1'b0;
        step();
        check("avg off pwr",     32'(adc_pwr2), 32'd1);
        check("avg off clk",     32'(adc_clk2), 32'd0);
        check("avg off running", 32'(run2),     32'd0);
        repeat (20) step();
        check("avg no partial push", 32'(rx2.size()), 32'(N_AVG));
        check("avg off valid",       32'(vld2),       32'd0);
        for (int r = 0; r < N_AVG && r < rx2.size(); r++)
            check($sformatf("avg vec%0d", r), 32'(rx2[r]), 32'(avg_tab[r].exp));

        // Re-enable repeats WAKE+FLUSH and starts from a fresh sum.
        tx2.delete();
        tx2.push_back(8'hAA);
        tx2.push_back(8'hBB);
        tx2.push_back(8'h04);
        tx2.push_back(8'h04);
        tx2.push_back(8'h04);
        tx2.push_back(8'h08);
        ready2 = 1'b0;
        en2    = 1'b1;
        step();
        check("rewake pwr", 32'(adc_pwr2), 32'd0);
        cnt = 1;
        while (!run2 && cnt < 40) begin
            step();
            cnt++;
        end
        check("rewake edges to running", 32'(cnt), 32'd14);
        for (int i = 0; i < 40 && !vld2; i++) step();
        check("rewake valid", 32'(vld2),  32'd1);
        check("rewake dout",  32'(dout2), 32'h05);
        repeat (3) step();
        check("stall valid held", 32'(vld2),  32'd1);
        check("stall dout held",  32'(dout2), 32'h05);

        // Reset mid-run with a non-empty FIFO.
        RST = 1'b1;
        #1;
        check("midrst pwr",     32'(adc_pwr2), 32'd1);
        check("midrst clk",     32'(adc_clk2), 32'd0);
        check("midrst valid",   32'(vld2),     32'd0);
        check("midrst dout",    32'(dout2),    32'd0);
        check("midrst ovf",     32'(ovf2),     32'd0);
        check("midrst running", 32'(run2),     32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step();
        check("postrst valid", 32'(vld2),     32'd0);
        check("postrst pwr",   32'(adc_pwr2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
